// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - double-buffered RGB565 framebuffer scanout with integer upscale and sync alignment
// Optional FB_SCANOUT_TEST_PATTERN_EN adds pattern_en_in, which selects 8 vertical colour bars.
module fb_scanout #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES    = 720,
  parameter int TOTAL_WIDTH     = 1650,
  parameter int TOTAL_LINES     = 750,
  parameter int LOG2_SCALE      = 2,
  parameter int BRAM_LATENCY    = 2,
  localparam int FB_W    = ACTIVE_H_PIXELS >> LOG2_SCALE,
  localparam int FB_H    = ACTIVE_LINES >> LOG2_SCALE,
  localparam int FB_SIZE = FB_W * FB_H,
  localparam int HC_W    = $clog2(TOTAL_WIDTH),
  localparam int VC_W    = $clog2(TOTAL_LINES),
  localparam int LB_W    = $clog2(FB_SIZE),
  localparam int ADDR_W  = $clog2(2 * FB_SIZE)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic [HC_W-1:0]   hcount_in,
  input  logic [VC_W-1:0]   vcount_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              ad_in,
  input  logic              nf_in,
  input  logic              swap_req_in,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
  input  logic              pattern_en_in,
`endif
  output logic              swap_ack_out,
  output logic              front_buf_out,
  output logic [ADDR_W-1:0] fb_addr_out,
  input  logic [15:0]       fb_data_in,
  output logic [7:0]        red_out,
  output logic [7:0]        green_out,
  output logic [7:0]        blue_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              ad_out
);

  localparam int LAT = 2 + BRAM_LATENCY;
  localparam logic [ADDR_W-1:0] FB_SIZE_A = ADDR_W'(FB_SIZE);
  localparam logic [LB_W-1:0]   FB_W_L    = LB_W'(FB_W);
  localparam logic [HC_W-1:0]   H_LAST    = HC_W'(TOTAL_WIDTH - 1);
  localparam logic [VC_W-1:0]   V_LAST    = VC_W'(TOTAL_LINES - 1);
  localparam logic [VC_W-1:0]   V_ACTIVE  = VC_W'(ACTIVE_LINES);

  logic [LB_W-1:0]   line_base;
  logic              front_buf;
  logic              swap_pending;
  logic              do_swap;
  logic              line_end;
  logic              frame_end;
  logic              last_sub_line;
  logic              row_done;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] offset_c;
  logic [ADDR_W-1:0] addr_next;
  logic [LAT-1:0]    hs_d;
  logic [LAT-1:0]    vs_d;
  logic [LAT-1:0]    ad_d;
  logic [4:0]        r5;
  logic [5:0]        g6;
  logic [4:0]        b5;

  assign line_end  = (hcount_in == H_LAST);
  assign frame_end = line_end && (vcount_in == V_LAST);

  generate
    if (LOG2_SCALE > 0) begin : g_sub
      assign last_sub_line = &vcount_in[LOG2_SCALE-1:0];
    end else begin : g_nosub
      assign last_sub_line = 1'b1;
    end
  endgenerate

  // Each framebuffer row is repeated 2**LOG2_SCALE times; advance after its last copy.
  assign row_done = line_end && (vcount_in < V_ACTIVE) && last_sub_line;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      line_base <= '0;
    end else if (frame_end) begin
      line_base <= '0;
    end else if (row_done) begin
      line_base <= line_base + FB_W_L;
    end
  end

  assign col    = ADDR_W'(hcount_in >> LOG2_SCALE);
  assign offset = ADDR_W'(line_base) + col;
  // Blanking positions can run past the buffer end; fold them to 0 so the address stays in range.
  assign offset_c  = (offset >= FB_SIZE_A) ? '0 : offset;
  assign addr_next = (front_buf ? FB_SIZE_A : '0) + offset_c;

  assign do_swap = nf_in && (swap_pending || swap_req_in);

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      front_buf    <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack_out <= 1'b0;
    end else begin
      swap_ack_out <= do_swap;
      if (do_swap) begin
        front_buf    <= ~front_buf;
        swap_pending <= 1'b0;
      end else if (swap_req_in) begin
        swap_pending <= 1'b1;
      end
    end
  end

  assign front_buf_out = front_buf;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      fb_addr_out <= '0;
      hs_d        <= '0;
      vs_d        <= '0;
      ad_d        <= '0;
    end else begin
      fb_addr_out <= addr_next;
      hs_d        <= {hs_d[LAT-2:0], hs_in};
      vs_d        <= {vs_d[LAT-2:0], vs_in};
      ad_d        <= {ad_d[LAT-2:0], ad_in};
    end
  end

  assign hs_out = hs_d[LAT-1];
  assign vs_out = vs_d[LAT-1];
  assign ad_out = ad_d[LAT-1];

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = HC_W + 3;

  logic [2:0]            bar_now;
  logic [2:0]            bar_d [BRAM_LATENCY+1];
  logic [BRAM_LATENCY:0] pat_d;

  assign bar_now = 3'({hcount_in, 3'b000} / BAR_W'(ACTIVE_H_PIXELS));

  // Bar index and enable travel alongside the BRAM read so they meet the data at the output stage.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i <= BRAM_LATENCY; i++) begin
        bar_d[i] <= '0;
      end
      pat_d <= '0;
    end else begin
      bar_d[0] <= bar_now;
      for (int i = 1; i <= BRAM_LATENCY; i++) begin
        bar_d[i] <= bar_d[i-1];
      end
      pat_d <= {pat_d[BRAM_LATENCY-1:0], pattern_en_in};
    end
  end
`endif

  assign r5 = fb_data_in[15:11];
  assign g6 = fb_data_in[10:5];
  assign b5 = fb_data_in[4:0];

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else if (!ad_d[LAT-2]) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    end else if (pat_d[BRAM_LATENCY]) begin
      red_out   <= {8{bar_d[BRAM_LATENCY][2]}};
      green_out <= {8{bar_d[BRAM_LATENCY][1]}};
      blue_out  <= {8{bar_d[BRAM_LATENCY][0]}};
`endif
    end else begin
      red_out   <= {r5, r5[4:2]};
      green_out <= {g6, g6[5:4]};
      blue_out  <= {b5, b5[4:2]};
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - scoreboard bench for fb_scanout driving a sparse 1280x720 timing sequence
module tb_fb_scanout;

  localparam int AW      = 17;
  localparam int FB_SIZE = 57600;

  typedef struct {
    int         due;
    logic [AW-1:0] addr;
    logic       addr_chk;
    logic       fb;
    logic       ack;
    int         vec;
  } ctrl_t;

  typedef struct {
    int          due;
    logic        hs;
    logic        vs;
    logic        ad;
    logic [23:0] rgb;
  } vid_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [10:0]   hcount = '0;
  logic [9:0]    vcount = '0;
  logic          hs_in = 1'b0;
  logic          vs_in = 1'b0;
  logic          ad_in = 1'b0;
  logic          nf_in = 1'b0;
  logic          swap_req = 1'b0;
  logic          pattern_en = 1'b0;
  logic          swap_ack;
  logic          front_buf;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_data = '0;
  logic [AW-1:0] bram_d1 = '0;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;
  logic          hs_out;
  logic          vs_out;
  logic          ad_out;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    frame = 0;
  logic  exp_fb = 1'b0;
  ctrl_t ctrl_q[$];
  vid_t  vid_q[$];

  int hset[15]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 160, 1279, 1280, 1400, 1649};
  int vec_f[8]  = '{0, 0, 1, 2, 2, 3, 4, 5};
  int vec_v[8]  = '{4, 719, 0, 0, 719, 0, 0, 4};
  int vec_h[8]  = '{8, 1279, 0, 0, 1279, 0, 0, 8};
  int vec_a[8]  = '{322, 57599, 0, 57600, 115199, 0, 57600, 322};

  fb_scanout dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .ad_in        (ad_in),
    .nf_in        (nf_in),
    .swap_req_in  (swap_req),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    .pattern_en_in(pattern_en),
`endif
    .swap_ack_out (swap_ack),
    .front_buf_out(front_buf),
    .fb_addr_out  (fb_addr),
    .fb_data_in   (fb_data),
    .red_out      (red),
    .green_out    (green),
    .blue_out     (blue),
    .hs_out       (hs_out),
    .vs_out       (vs_out),
    .ad_out       (ad_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model, two-cycle read latency; a few addresses hold hand-picked colours
  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    case (a)
      17'd1:   return 16'hF800;
      17'd2:   return 16'h07E0;
      17'd3:   return 16'h0841;
      default: return a[15:0];
    endcase
  endfunction

  always @(posedge clk) begin
    bram_d1 <= fb_addr;
    fb_data <= mem_word(bram_d1);
  end

  function automatic logic [23:0] expand(input logic [15:0] d);
    logic [7:0] r8, g8, b8;
    r8 = 8'((d[15:11] * 8) + (d[15:11] / 4));
    g8 = 8'((d[10:5] * 4) + (d[10:5] / 16));
    b8 = 8'((d[4:0] * 8) + (d[4:0] / 4));
    return {r8, g8, b8};
  endfunction

  function automatic logic [23:0] exp_pixel(input logic [AW-1:0] a);
    case (a)
      17'd1:   return 24'hFF0000;
      17'd2:   return 24'h00FF00;
      17'd3:   return 24'h080808;
      default: return expand(a[15:0]);
    endcase
  endfunction

  function automatic int vec_addr(input int f, input int v, input int h);
    for (int i = 0; i < 8; i++) begin
      if (vec_f[i] == f && vec_v[i] == v && vec_h[i] == h) return vec_a[i];
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int v, input int h, input logic req, input logic nf, input logic swp);
    ctrl_t c;
    vid_t d;
    logic [AW-1:0] a;
    logic act;
    logic [2:0] bar;
    @(negedge clk);
    act = (h < 1280) && (v < 720);
    a = AW'((exp_fb ? FB_SIZE : 0) + (v / 4) * 320 + h / 4);
    hcount   = 11'(h);
    vcount   = 10'(v);
    hs_in    = (h == 1400);
    vs_in    = (v >= 725) && (v < 730);
    ad_in    = act;
    nf_in    = nf;
    swap_req = req;
    c.due = cyc + 1;
    c.addr = a;
    c.addr_chk = act;
    c.vec = vec_addr(frame, v, h);
    if (swp) exp_fb = ~exp_fb;
    c.fb = exp_fb;
    c.ack = swp;
    ctrl_q.push_back(c);
    bar = 3'(h * 8 / 1280);
    d.due = cyc + 4;
    d.hs = hs_in;
    d.vs = vs_in;
    d.ad = act;
    if (!act) d.rgb = 24'h0;
    else if (pattern_en) d.rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
    else d.rgb = exp_pixel(a);
    vid_q.push_back(d);
  endtask

  task automatic run_lines(input int v0, input int v1, input int req_v1, input int req_v2,
                           input logic swap_at_nf);
    for (int v = v0; v <= v1; v++) begin
      for (int k = 0; k < 15; k++) begin
        logic nf, req;
        nf  = (v == 720) && (hset[k] == 0);
        req = (hset[k] == 0) && (v == req_v1 || v == req_v2);
        drive(v, hset[k], req, nf, nf && swap_at_nf);
      end
    end
  endtask

  // Monitor: pops expectations when their cycle comes due
  always @(negedge clk) begin
    ctrl_t c;
    vid_t d;
    while (ctrl_q.size() > 0 && ctrl_q[0].due <= cyc) begin
      c = ctrl_q.pop_front();
      check("ctrl_due", c.due, cyc);
      check("front_buf", 32'(front_buf), 32'(c.fb));
      check("swap_ack", 32'(swap_ack), 32'(c.ack));
      check("addr_range", 32'(fb_addr < 17'd115200), 32'd1);
      if (c.addr_chk) check("addr", 32'(fb_addr), 32'(c.addr));
      if (c.vec >= 0) check("addr_vec", 32'(fb_addr), c.vec);
    end
    while (vid_q.size() > 0 && vid_q[0].due <= cyc) begin
      d = vid_q.pop_front();
      check("vid_due", d.due, cyc);
      check("rgb", 32'({red, green, blue}), 32'(d.rgb));
      check("syncs", 32'({hs_out, vs_out, ad_out}), 32'({d.hs, d.vs, d.ad}));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: cycle %0d exceeded time limit", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rgb", 32'({red, green, blue}), 32'h0);
    check("reset_ctrl", 32'({hs_out, vs_out, ad_out, swap_ack, front_buf}), 32'h0);
    check("reset_addr", 32'(fb_addr), 32'h0);
    rst = 1'b0;

    frame = 0; run_lines(0, 749, -1, -1, 1'b0);
    frame = 1; run_lines(0, 749, 100, 200, 1'b1);
    frame = 2; run_lines(0, 749, 720, -1, 1'b1);
    frame = 3; run_lines(0, 749, 300, -1, 1'b1);
    frame = 4; run_lines(0, 11, -1, -1, 1'b0);
    for (int k = 0; k < 9; k++) drive(12, hset[k], 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rgb", 32'({red, green, blue}), 32'h0);
    check("async_rst_ctrl", 32'({hs_out, vs_out, ad_out, swap_ack, front_buf}), 32'h0);
    check("async_rst_addr", 32'(fb_addr), 32'h0);
    ctrl_q.delete();
    vid_q.delete();
    exp_fb   = 1'b0;
    hcount   = '0;
    vcount   = '0;
    hs_in    = 1'b0;
    vs_in    = 1'b0;
    ad_in    = 1'b0;
    nf_in    = 1'b0;
    swap_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    frame = 5; run_lines(0, 5, -1, -1, 1'b0);
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    pattern_en = 1'b1;
`endif
    run_lines(6, 9, -1, -1, 1'b0);

    repeat (6) @(negedge clk);
    #1;
    check("drain", 32'(ctrl_q.size() + vid_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
